// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle WIDTH-bit adder built from one DIGIT-wide slice.
// Operands enter through a valid/ready handshake. The slice consumes DIGIT bits per
// clock, LSB digit first, and carries between digits through a carry register.
// sum, cout and ovf are registered and hold their values until the next addition.
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int DW = DIGIT + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  // Illegal geometries are rejected at elaboration.
  if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("digit_serial_adder: illegal WIDTH/DIGIT combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;

  logic [DW-1:0]     slice_s;
  logic              msb_cin_s;
  logic              slice_ovf_s;

  // Digit slice: low DIGIT bits of both operands plus the running carry.
  assign slice_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_r[DIGIT-1:0]} + DW'(carry_r);

  // Carry into the slice MSB is recovered from the MSB sum bit, so no second
  // narrower adder is needed; in the last digit this is the carry into bit WIDTH-1.
  assign msb_cin_s   = a_r[DIGIT-1] ^ b_r[DIGIT-1] ^ slice_s[DIGIT-1];
  assign slice_ovf_s = msb_cin_s ^ slice_s[DIGIT];

  // Handshake and status flags are plain decodes of the state register.
  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);

  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

  // Control FSM and datapath registers: capture, digit-serial add, result hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            cnt_r   <= {CW{1'b0}};
            state_r <= RUN;
          end
        end
        RUN: begin
          sum_r[int'(cnt_r)*DIGIT +: DIGIT] <= slice_s[DIGIT-1:0];
          carry_r <= slice_s[DIGIT];
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_CNT) begin
            cout_r  <= slice_s[DIGIT];
            ovf_r   <= slice_ovf_s;
            state_r <= DONE;
          end
        end
        DONE: begin
          // in_valid is deliberately ignored here; operands are never overlapped.
          if (out_ready) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Parametrised multi-cycle adder for the arithmetic library. It adds two WIDTH-bit operands plus a carry-in, processing DIGIT bits per clock through a registered carry. Operands enter through a valid/ready handshake and the result leaves through one. The block sits where area matters more than throughput: one DIGIT-wide adder slice replaces a full WIDTH-bit carry chain.

## Interface
- WIDTH, 32: operand and sum width in bits; WIDTH ≥ 1.
- DIGIT, 4: bits added per cycle; 1 ≤ DIGIT ≤ WIDTH; WIDTH % DIGIT == 0 (elaboration error otherwise).
- Derived: N = WIDTH/DIGIT (cycles per addition); counter width = max(1, clog2(N)).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: capture a, b into shift registers and cin into the carry register; clear the digit counter; go to RUN.
- RUN:
  - Each cycle, add the low DIGIT bits of a_reg and b_reg plus the carry register.
  - Write the DIGIT-bit result into the sum register at digit position cnt, LSB digit first.
  - Update the carry register with the slice carry-out.
  - Shift a_reg and b_reg right by DIGIT; increment cnt.
- RUN, last digit (cnt == N-1):
  - cout ← slice carry-out.
  - ovf ← carry into the MSB XOR carry out of the MSB, computed inside the last slice.
  - Go to DONE.
- DONE:
  - out_valid = 1.
  - On out_ready: go to IDLE.
  - in_valid is ignored while in DONE.
- Outputs:
  - in_ready = (state == IDLE) and out_valid = (state == DONE), both decoded combinationally from the state register.
  - sum, cout and ovf are registered and change only during RUN. They hold their values through DONE and the following IDLE.
  - sum contents during RUN are partial and undefined for consumers.
- Arithmetic: unsigned modulo-2^WIDTH sum. The signed interpretation is valid through ovf.
- DIGIT == WIDTH is legal: the block degenerates to a 1-cycle registered adder (N = 1).

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, cnt = 0, and a_reg, b_reg, carry, sum, cout, ovf all = 0. Resulting outputs: in_ready = 1, out_valid = 0, busy = 0.
- Reset mid-RUN or mid-DONE aborts the addition immediately; the result is lost.
- Accept edge E0 is the clock edge where in_valid && in_ready. Digits are processed on edges E1..EN. out_valid is high from just after EN.
- Latency: N cycles from acceptance to out_valid.
- Result handoff edge is where out_valid && out_ready. in_ready rises after this edge, so the next accept occurs no earlier than the following edge.
- Throughput: one addition per N+2 cycles with in_valid and out_ready held high. Operands are not overlapped.
- Backpressure: out_ready low holds DONE indefinitely. sum, cout, ovf and out_valid stay stable, and in_ready stays 0.
- in_valid may toggle freely outside IDLE with no effect. Operands need to be stable only on the accept edge.

## Test plan
- WIDTH=8, DIGIT=2, inputs a=0xFF, b=0x01, cin=0:
  - out_valid exactly 4 cycles after accept.
  - sum=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=2, inputs a=0x7F, b=0x01, cin=0, then a=0x80, b=0x80:
  - first result: sum=0x80, cout=0, ovf=1.
  - second result: sum=0x00, cout=1, ovf=1.
- WIDTH=8, DIGIT=1, inputs a=0x00, b=0x00, cin=1:
  - out_valid 8 cycles after accept, sum=0x01, cout=0.
  - in_ready low throughout RUN and DONE.
- Backpressure, DIGIT=2: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands.
  - result stays stable, in_ready stays 0, and the new operands are not captured.
  - after out_ready=1, in_ready returns one cycle later.
- Reset mid-RUN: assert rst_n=0 at cnt=2 of a WIDTH=8, DIGIT=2 addition.
  - all outputs return to reset values asynchronously.
  - after release, an addition of 0x12+0x34 gives 0x46.
- WIDTH=8, DIGIT=8, 200 random operand/cin sets with random out_ready stalls:
  - latency 1 per operation.
  - every result matches the reference a+b+cin, including cout and ovf.
